// File: rtl/bitstream_loader_pkg.sv
// Shared definitions for the bitstream configuration loader.
//   - state_t        : loader FSM states
//   - ENTRY_*        : bit slices of a 64-bit bitstream entry ({addr, data})
//   - DEF_*          : default parameter values
//   - clamp_size()   : limit a requested load size to the memory depth
package bitstream_loader_pkg;

  localparam int DEF_BITSTREAM_MAX_SIZE = 4096;
  localparam int DEF_NUM_CYCLES         = 20000;
  localparam int DEF_FLUSH_STALL_CYCLES = 16;
  localparam int DEF_FLUSH_RUN_CYCLES   = 2;

  localparam int ENTRY_W       = 64;
  localparam int CFG_W         = 32;
  localparam int SIZE_W        = 13;
  localparam int RD_ADDR_W     = 12;

  localparam int ENTRY_ADDR_HI = 63;
  localparam int ENTRY_ADDR_LO = 32;
  localparam int ENTRY_DATA_HI = 31;
  localparam int ENTRY_DATA_LO = 0;

  typedef enum logic [2:0] {
    IDLE,
    CONFIG,
    FLUSH_STALL,
    FLUSH_RUN,
    RUN,
    DONE,
    TIMEOUT
  } state_t;

  function automatic logic [SIZE_W-1:0] clamp_size(input logic [SIZE_W-1:0] sz,
                                                   input int max_size);
    return (int'(sz) > max_size) ? SIZE_W'(max_size) : sz;
  endfunction

endpackage

// File: rtl/config_word_pipe.sv
// Read-to-write pipeline for bitstream entries.
// A read issued in cycle t returns data in t+1; that entry is split into
// address/data and presented on the config bus with cfg_write in t+2.
// Ports:
//   clk, reset   : clock, synchronous active-high reset (drops in-flight reads)
//   rd_en        : read enable as issued to the bitstream memory
//   rd_data      : entry returned by the memory (valid the cycle after rd_en)
//   pending      : a read is in flight whose write has not been issued yet
//   cfg_write    : config write strobe
//   cfg_addr/data: config bus address/data, held when cfg_write is low
module config_word_pipe
  import bitstream_loader_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               rd_en,
  input  logic [ENTRY_W-1:0] rd_data,
  output logic               pending,
  output logic               cfg_write,
  output logic [CFG_W-1:0]   cfg_addr,
  output logic [CFG_W-1:0]   cfg_data
);

  logic             vld_q, vld_d;
  logic             wr_q, wr_d;
  logic [CFG_W-1:0] addr_q, addr_d;
  logic [CFG_W-1:0] data_q, data_d;

  always_comb begin
    vld_d  = rd_en;
    wr_d   = vld_q;
    addr_d = addr_q;
    data_d = data_q;
    if (vld_q) begin
      addr_d = rd_data[ENTRY_ADDR_HI:ENTRY_ADDR_LO];
      data_d = rd_data[ENTRY_DATA_HI:ENTRY_DATA_LO];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q  <= 1'b0;
      wr_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      wr_q   <= wr_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign pending   = vld_q;
  assign cfg_write = wr_q;
  assign cfg_addr  = addr_q;
  assign cfg_data  = data_q;

endmodule

// File: rtl/bitstream_config_loader.sv
// Loads a bitstream of {addr, data} entries onto the array config bus,
// flushes the array, then runs it until done or a cycle-count timeout.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   start               : pulse; honoured only in IDLE/DONE/TIMEOUT
//   bitstream_size      : entries to load (clamped to BITSTREAM_MAX_SIZE)
//   bs_rd_en/addr/data  : bitstream memory read port (1-cycle latency)
//   config_*            : config bus (config_read is always 0)
//   stall, flush        : array control
//   done                : array completion, observed only in RUN
//   busy/finished/timed_out : status
//   cycle_count         : RUN cycles counted for the current sequence
module bitstream_config_loader
  import bitstream_loader_pkg::*;
#(
  parameter int BITSTREAM_MAX_SIZE = DEF_BITSTREAM_MAX_SIZE,
  parameter int NUM_CYCLES         = DEF_NUM_CYCLES,
  parameter int FLUSH_STALL_CYCLES = DEF_FLUSH_STALL_CYCLES,
  parameter int FLUSH_RUN_CYCLES   = DEF_FLUSH_RUN_CYCLES
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [SIZE_W-1:0]    bitstream_size,
  output logic                 bs_rd_en,
  output logic [RD_ADDR_W-1:0] bs_rd_addr,
  input  logic [ENTRY_W-1:0]   bs_rd_data,
  output logic [CFG_W-1:0]     config_config_addr,
  output logic [CFG_W-1:0]     config_config_data,
  output logic                 config_write,
  output logic                 config_read,
  output logic                 stall,
  output logic                 flush,
  input  logic                 done,
  output logic                 busy,
  output logic                 finished,
  output logic                 timed_out,
  output logic [63:0]          cycle_count
);

  state_t               state_q, state_d;
  logic [SIZE_W-1:0]    eff_q, eff_d;
  logic [SIZE_W-1:0]    req_size;
  logic                 rd_en_q, rd_en_d;
  logic [RD_ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [31:0]          fcnt_q, fcnt_d;
  logic [63:0]          cnt_q, cnt_d;
  logic                 stall_q, stall_d;
  logic                 flush_q, flush_d;
  logic                 busy_q, busy_d;
  logic                 fin_q, fin_d;
  logic                 to_q, to_d;
  logic                 pipe_pending;

  config_word_pipe u_pipe (
    .clk       (clk),
    .reset     (reset),
    .rd_en     (rd_en_q),
    .rd_data   (bs_rd_data),
    .pending   (pipe_pending),
    .cfg_write (config_write),
    .cfg_addr  (config_config_addr),
    .cfg_data  (config_config_data)
  );

  assign req_size = clamp_size(bitstream_size, BITSTREAM_MAX_SIZE);

  always_comb begin
    state_d   = state_q;
    eff_d     = eff_q;
    rd_en_d   = rd_en_q;
    rd_addr_d = rd_addr_q;
    fcnt_d    = fcnt_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE, DONE, TIMEOUT: begin
        if (start) begin
          eff_d     = req_size;
          cnt_d     = '0;
          fcnt_d    = '0;
          rd_addr_d = '0;
          if (req_size != '0) begin
            state_d = CONFIG;
            rd_en_d = 1'b1;
          end else begin
            state_d = FLUSH_STALL;
          end
        end
      end
      CONFIG: begin
        if (rd_en_q) begin
          if ({1'b0, rd_addr_q} == eff_q - SIZE_W'(1)) rd_en_d = 1'b0;
          else rd_addr_d = rd_addr_q + RD_ADDR_W'(1);
        end
        // Reads finished and nothing in flight: this write is the last one.
        if (!rd_en_q && !pipe_pending && config_write) state_d = FLUSH_STALL;
      end
      FLUSH_STALL: begin
        if (fcnt_q == 32'(FLUSH_STALL_CYCLES - 1)) begin
          fcnt_d  = '0;
          state_d = FLUSH_RUN;
        end else begin
          fcnt_d = fcnt_q + 32'd1;
        end
      end
      FLUSH_RUN: begin
        if (fcnt_q == 32'(FLUSH_RUN_CYCLES - 1)) begin
          fcnt_d  = '0;
          state_d = RUN;
        end else begin
          fcnt_d = fcnt_q + 32'd1;
        end
      end
      RUN: begin
        // done takes priority over reaching the limit in the same cycle.
        if (done) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 64'd1;
          if (cnt_d == 64'(NUM_CYCLES)) state_d = TIMEOUT;
        end
      end
      default: state_d = IDLE;
    endcase

    // Status/control outputs are decoded from the next state so the
    // registered copies line up with the state they describe.
    stall_d = !(state_d inside {FLUSH_RUN, RUN});
    flush_d = state_d inside {FLUSH_STALL, FLUSH_RUN};
    busy_d  = !(state_d inside {IDLE, DONE, TIMEOUT});
    fin_d   = (state_d == DONE);
    to_d    = (state_d == TIMEOUT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      eff_q     <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      fcnt_q    <= '0;
      cnt_q     <= '0;
      stall_q   <= 1'b1;
      flush_q   <= 1'b0;
      busy_q    <= 1'b0;
      fin_q     <= 1'b0;
      to_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      eff_q     <= eff_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      fcnt_q    <= fcnt_d;
      cnt_q     <= cnt_d;
      stall_q   <= stall_d;
      flush_q   <= flush_d;
      busy_q    <= busy_d;
      fin_q     <= fin_d;
      to_q      <= to_d;
    end
  end

  assign bs_rd_en    = rd_en_q;
  assign bs_rd_addr  = rd_addr_q;
  assign config_read = 1'b0;
  assign stall       = stall_q;
  assign flush       = flush_q;
  assign busy        = busy_q;
  assign finished    = fin_q;
  assign timed_out   = to_q;
  assign cycle_count = cnt_q;

endmodule

// File: tb/tb_bitstream_config_loader.sv
// Directed bench for bitstream_config_loader. A second instance with a
// short timeout covers the timeout path.
module tb_bitstream_config_loader;

  logic        clk = 1'b0;
  logic        reset, start, done;
  logic [12:0] bitstream_size;
  logic        bs_rd_en;
  logic [11:0] bs_rd_addr;
  logic [63:0] bs_rd_data;
  logic [31:0] config_config_addr, config_config_data;
  logic        config_write, config_read, stall, flush, busy, finished, timed_out;
  logic [63:0] cycle_count;

  logic        start_to, done_to;
  logic [12:0] size_to;
  logic        bs_rd_en_to;
  logic [11:0] bs_rd_addr_to;
  logic [63:0] bs_rd_data_to;
  logic [31:0] cfg_addr_to, cfg_data_to;
  logic        cfg_write_to, cfg_read_to, stall_to, flush_to, busy_to, finished_to, timed_out_to;
  logic [63:0] cycle_count_to;

  logic [63:0] mem [0:4095];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc;

  // Monitor state
  logic        mon_clr = 1'b0;
  int          rd_n, wr_n, fl_n, fls_n, first_rd, first_wr, last_wr;
  logic [11:0] last_rd_addr;
  logic [63:0] wr_log[$];

  always #5 clk = ~clk;

  bitstream_config_loader dut (
    .clk(clk), .reset(reset), .start(start), .bitstream_size(bitstream_size),
    .bs_rd_en(bs_rd_en), .bs_rd_addr(bs_rd_addr), .bs_rd_data(bs_rd_data),
    .config_config_addr(config_config_addr), .config_config_data(config_config_data),
    .config_write(config_write), .config_read(config_read),
    .stall(stall), .flush(flush), .done(done), .busy(busy),
    .finished(finished), .timed_out(timed_out), .cycle_count(cycle_count)
  );

  bitstream_config_loader #(.NUM_CYCLES(50)) dut_to (
    .clk(clk), .reset(reset), .start(start_to), .bitstream_size(size_to),
    .bs_rd_en(bs_rd_en_to), .bs_rd_addr(bs_rd_addr_to), .bs_rd_data(bs_rd_data_to),
    .config_config_addr(cfg_addr_to), .config_config_data(cfg_data_to),
    .config_write(cfg_write_to), .config_read(cfg_read_to),
    .stall(stall_to), .flush(flush_to), .done(done_to), .busy(busy_to),
    .finished(finished_to), .timed_out(timed_out_to), .cycle_count(cycle_count_to)
  );

  // Bitstream memories: one cycle read latency.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bs_rd_en)    bs_rd_data    <= mem[bs_rd_addr];
    if (bs_rd_en_to) bs_rd_data_to <= mem[bs_rd_addr_to];
  end

  always @(negedge clk) begin
    if (mon_clr) begin
      rd_n = 0; wr_n = 0; fl_n = 0; fls_n = 0;
      first_rd = -1; first_wr = -1; last_wr = -1; last_rd_addr = '0;
      wr_log.delete();
    end else begin
      if (bs_rd_en) begin
        if (rd_n == 0) first_rd = cyc;
        rd_n++;
        last_rd_addr = bs_rd_addr;
      end
      if (config_write) begin
        if (wr_n == 0) first_wr = cyc;
        wr_n++;
        last_wr = cyc;
        wr_log.push_back({config_config_addr, config_config_data});
      end
      if (flush) begin
        fl_n++;
        if (stall) fls_n++;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    @(negedge clk);
    #1 mon_clr = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_run(input string tag, input int lim);
    for (int k = 0; k < lim && !(stall === 1'b0 && flush === 1'b0); k++) step(1);
    chk(tag, {62'd0, stall, flush}, 64'd0);
  endtask

  task automatic finish_run();
    done = 1'b1;
    step(1);
    done = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++)
      mem[i] = {32'h4000_0000 + 32'(i), 32'h5A00_0000 ^ 32'(i)};
    mem[0] = 64'h00010000_000000AA;
    mem[1] = 64'h00020000_000000BB;
    mem[2] = 64'h00030000_000000CC;

    reset = 1'b1; start = 1'b0; done = 1'b0; bitstream_size = '0;
    start_to = 1'b0; done_to = 1'b0; size_to = '0;
    step(2);
    chk("rst_stall", 64'(stall), 64'd1);
    chk("rst_flush", 64'(flush), 64'd0);
    chk("rst_write", 64'(config_write), 64'd0);
    chk("rst_read", 64'(config_read), 64'd0);
    chk("rst_rd_en", 64'(bs_rd_en), 64'd0);
    chk("rst_rd_addr", 64'(bs_rd_addr), 64'd0);
    chk("rst_cfg_addr", 64'(config_config_addr), 64'd0);
    chk("rst_cfg_data", 64'(config_config_data), 64'd0);
    chk("rst_count", cycle_count, 64'd0);
    chk("rst_status", {61'd0, busy, finished, timed_out}, 64'd0);
    reset = 1'b0;
    step(2);
    chk("idle_stall", {62'd0, stall, flush}, 64'd2);

    // 3-entry load, then done on the 100th RUN cycle.
    clear_mon();
    bitstream_size = 13'd3;
    pulse_start();
    chk("cfg_ctrl", {61'd0, busy, stall, flush}, 64'd6);
    chk("cfg_rd0", {51'd0, bs_rd_en, bs_rd_addr}, {51'd0, 1'b1, 12'd0});
    wait_run("run3_reached", 100);
    chk("w3_count", 64'(wr_n), 64'd3);
    chk("w3_rd_count", 64'(rd_n), 64'd3);
    chk("w3_w0", wr_log[0], 64'h00010000_000000AA);
    chk("w3_w1", wr_log[1], 64'h00020000_000000BB);
    chk("w3_w2", wr_log[2], 64'h00030000_000000CC);
    chk("w3_lat", 64'(first_wr - first_rd), 64'd2);
    chk("w3_b2b", 64'(last_wr - first_wr), 64'd2);
    chk("w3_flush_n", 64'(fl_n), 64'd18);
    chk("w3_flush_stall_n", 64'(fls_n), 64'd16);
    chk("w3_hold", {config_config_addr, config_config_data}, 64'h00030000_000000CC);
    chk("w3_hold_wr", 64'(config_write), 64'd0);
    chk("run_count0", cycle_count, 64'd0);
    step(99);
    done = 1'b1;
    step(1);
    done = 1'b0;
    chk("done_status", {61'd0, busy, finished, timed_out}, 64'd2);
    chk("done_count", cycle_count, 64'd99);
    chk("done_ctrl", {62'd0, stall, flush}, 64'd2);
    done = 1'b1;
    step(3);
    done = 1'b0;
    chk("done_hold", cycle_count, 64'd99);

    // Zero-size load restarted from DONE.
    clear_mon();
    bitstream_size = 13'd0;
    start_cyc = cyc;
    pulse_start();
    chk("z_count_clr", cycle_count, 64'd0);
    chk("z_status", {60'd0, busy, finished, stall, flush}, 64'hB);
    wait_run("z_run_reached", 40);
    chk("z_run_lat", 64'(cyc - start_cyc), 64'd19);
    chk("z_no_rd", 64'(rd_n), 64'd0);
    chk("z_no_wr", 64'(wr_n), 64'd0);
    chk("z_flush_n", 64'(fl_n), 64'd18);
    chk("z_flush_stall_n", 64'(fls_n), 64'd16);
    finish_run();
    chk("z_done", {61'd0, busy, finished, timed_out}, 64'd2);
    chk("z_done_count", cycle_count, 64'd0);

    // Oversized load is clamped to 4096 entries.
    clear_mon();
    bitstream_size = 13'd5000;
    pulse_start();
    for (int k = 0; k < 4200 && flush !== 1'b1; k++) step(1);
    chk("big_flush", 64'(flush), 64'd1);
    chk("big_wr_n", 64'(wr_n), 64'd4096);
    chk("big_rd_n", 64'(rd_n), 64'd4096);
    chk("big_last_rd", 64'(last_rd_addr), 64'd4095);
    chk("big_last_wr", {config_config_addr, config_config_data}, mem[4095]);
    wait_run("big_run", 40);
    finish_run();

    // start during CONFIG is ignored.
    clear_mon();
    bitstream_size = 13'd10;
    pulse_start();
    step(3);
    bitstream_size = 13'd2;
    pulse_start();
    for (int k = 0; k < 40 && flush !== 1'b1; k++) step(1);
    chk("ign_flush", 64'(flush), 64'd1);
    chk("ign_wr_n", 64'(wr_n), 64'd10);
    chk("ign_rd_n", 64'(rd_n), 64'd10);
    chk("ign_last_wr", {config_config_addr, config_config_data}, mem[9]);
    wait_run("ign_run", 40);
    finish_run();

    // Reset during the 2nd write of a 10-entry load.
    clear_mon();
    bitstream_size = 13'd10;
    pulse_start();
    for (int k = 0; k < 20 && config_write !== 1'b1; k++) step(1);
    chk("mid_first_wr", 64'(config_write), 64'd1);
    step(1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("mid_wr", 64'(config_write), 64'd0);
    chk("mid_rd", {51'd0, bs_rd_en, bs_rd_addr}, 64'd0);
    chk("mid_cfg", {config_config_addr, config_config_data}, 64'd0);
    chk("mid_ctrl", {59'd0, stall, flush, busy, finished, timed_out}, 64'h10);
    chk("mid_count", cycle_count, 64'd0);
    step(6);
    chk("mid_wr_n", 64'(wr_n), 64'd2);
    chk("mid_idle", {62'd0, busy, config_write}, 64'd0);

    // Timeout instance: no done.
    start_to = 1'b1;
    step(1);
    start_to = 1'b0;
    for (int k = 0; k < 200 && timed_out_to !== 1'b1; k++) step(1);
    chk("to_flag", {61'd0, busy_to, finished_to, timed_out_to}, 64'd1);
    chk("to_count", cycle_count_to, 64'd50);
    chk("to_stall", {62'd0, stall_to, flush_to}, 64'd2);

    // done coincides with the limit: DONE wins.
    start_to = 1'b1;
    step(1);
    start_to = 1'b0;
    chk("co_clr", cycle_count_to, 64'd0);
    for (int k = 0; k < 40 && !(stall_to === 1'b0 && flush_to === 1'b0); k++) step(1);
    chk("co_run", {62'd0, stall_to, flush_to}, 64'd0);
    step(49);
    done_to = 1'b1;
    step(1);
    done_to = 1'b0;
    chk("co_status", {61'd0, busy_to, finished_to, timed_out_to}, 64'd2);
    chk("co_count", cycle_count_to, 64'd49);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
